// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the NREQ writeback sources and the register-file write port.
// The arbiter takes the slave modport; whoever drives the requests takes master.
interface regfile_wb_arbiter_if #(
    parameter int NREQ = 3,
    parameter int DW   = 32,
    parameter int AW   = 5
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*AW-1:0] req_wsel;
    logic [NREQ*DW-1:0] req_data;
    logic               rf_wen;
    logic [AW-1:0]      rf_wsel;
    logic [DW-1:0]      rf_in;
    logic [2**AW-1:0]   pend_mask;
    logic               drop_err;
    logic [7:0]         drop_cnt;

    modport slave (
        input  req_valid, req_wsel, req_data,
        output req_ready, rf_wen, rf_wsel, rf_in, pend_mask, drop_err, drop_cnt
    );

    modport master (
        output req_valid, req_wsel, req_data,
        input  req_ready, rf_wen, rf_wsel, rf_in, pend_mask, drop_err, drop_cnt
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the single register-file write port among NREQ writeback sources.
// Writes aimed at the hardwired registers 0..PROT_REGS-1 are accepted, suppressed and counted.
module regfile_wb_arbiter #(
    parameter int NREQ      = 3,
    parameter int DW        = 32,
    parameter int AW        = 5,
    parameter int PROT_REGS = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_wb_arbiter_if.slave  wb
);
    localparam int PW    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int NREGS = 2**AW;

    logic [PW-1:0]    rr_ptr;
    logic [PW-1:0]    win;
    logic [PW-1:0]    win_next;
    logic             found;
    logic [NREQ-1:0]  grant;
    logic [AW-1:0]    win_wsel;
    logic [DW-1:0]    win_data;
    logic             win_prot;
    logic [NREGS-1:0] one_hot;

    logic             rf_wen_q;
    logic [AW-1:0]    rf_wsel_q;
    logic [DW-1:0]    rf_in_q;
    logic [NREGS-1:0] pend_mask_q;
    logic             drop_err_q;
    logic [7:0]       drop_cnt_q;

    // Scan from rr_ptr upward (wrapping); the first valid requester wins.
    // NOTE: every signal written here gets a default before the loop, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant = '0;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int cand;
            cand = (int'(rr_ptr) + k) % NREQ;
            if (!found && wb.req_valid[cand]) begin
                found       = 1'b1;
                win         = PW'(cand);
                grant[cand] = 1'b1;
            end
        end
    end

    assign win_next = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
    assign win_wsel = wb.req_wsel[win*AW +: AW];
    assign win_data = wb.req_data[win*DW +: DW];
    assign win_prot = (win_wsel < AW'(PROT_REGS));
    assign one_hot  = {{(NREGS-1){1'b0}}, 1'b1} << win_wsel;

    // Grants are withheld while reset is held so no source believes it transferred.
    assign wb.req_ready = reset ? grant : '0;

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr      <= '0;
            rf_wen_q    <= 1'b0;
            rf_wsel_q   <= '0;
            rf_in_q     <= '0;
            pend_mask_q <= '0;
            drop_err_q  <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            rf_wen_q    <= 1'b0;
            pend_mask_q <= '0;
            drop_err_q  <= 1'b0;
            if (found) begin
                rr_ptr    <= win_next;
                rf_wsel_q <= win_wsel;
                rf_in_q   <= win_data;
                if (win_prot) begin
                    drop_err_q <= 1'b1;
                    if (drop_cnt_q != 8'hFF) begin
                        drop_cnt_q <= drop_cnt_q + 8'd1;
                    end
                end else begin
                    rf_wen_q    <= 1'b1;
                    pend_mask_q <= one_hot;
                end
            end
        end
    end

    assign wb.rf_wen    = rf_wen_q;
    assign wb.rf_wsel   = rf_wsel_q;
    assign wb.rf_in     = rf_in_q;
    assign wb.pend_mask = pend_mask_q;
    assign wb.drop_err  = drop_err_q;
    assign wb.drop_cnt  = drop_cnt_q;
endmodule
